// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding, default address map
// and the fixed slot assignment of the MCU peripherals.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int          DEF_SLOT_BITS = 12;

    localparam int SLOT_RAM   = 0;
    localparam int SLOT_GPO   = 1;
    localparam int SLOT_GPI   = 2;
    localparam int SLOT_GPIOC = 3;
    localparam int SLOT_GPIOD = 4;
    localparam int SLOT_FND   = 5;
    localparam int SLOT_TIMER = 6;
    localparam int SLOT_UART  = 7;
    localparam int SLOT_US    = 8;
    localparam int SLOT_DHT   = 9;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slot decoder: maps a byte address onto a one-hot slave select,
// a hit flag and the binary slot index. Shared with the bus monitor.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_SLAVES = 10,
    parameter int                SLOT_BITS  = DEF_SLOT_BITS,
    parameter int                IDX_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot;

    assign offset = addr - BASE_ADDR;
    assign slot   = offset >> SLOT_BITS;

    // Addresses below the base wrap to huge offsets, so the lower bound is checked explicitly.
    assign hit = (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));
    assign idx = slot[IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = hit && (slot == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master_n.sv
// APB master bridging the core data port to NUM_SLAVES peripherals, with
// decode-miss errors, a stalled-slave timeout and an error flag back to the core.
module apb_master_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 10,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter int                SLOT_BITS  = DEF_SLOT_BITS,
    parameter int                TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         error,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_DECERR = DECERR;

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;

    logic                  slv_ready;
    logic                  slv_err;
    logic [DATA_W-1:0]     slv_rdata;
    logic                  timeout_hit;

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_BITS  (SLOT_BITS),
        .IDX_W      (IDX_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .addr (addr),
        .sel  (dec_sel),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the slave latched at request time is listened to; the others are don't-care.
    assign slv_ready   = PREADY[idx_reg];
    assign slv_err     = PSLVERR[idx_reg];
    assign slv_rdata   = PRDATA[int'(idx_reg) * DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PENABLE   <= 1'b0;
            PSEL      <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (transfer) begin
                        PADDR   <= addr;
                        PWDATA  <= wdata;
                        PWRITE  <= write;
                        idx_reg <= dec_idx;
                        if (dec_hit) begin
                            PSEL      <= dec_sel;
                            cnt_reg   <= '0;
                            state_reg <= ST_SETUP;
                        end else begin
                            state_reg <= ST_DECERR;
                        end
                    end
                end
                ST_SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (slv_ready) begin
                        rdata     <= PWRITE ? '0 : slv_rdata;
                        error     <= slv_err;
                        ready     <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (timeout_hit) begin
                        rdata     <= '0;
                        error     <= 1'b1;
                        ready     <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DECERR: begin
                    rdata     <= '0;
                    error     <= 1'b1;
                    ready     <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_n.sv
// Directed bench for apb_master_n: ten slots driven by a small wait-state slave
// model, TIMEOUT reduced to 4 so stalls are cheap to provoke.
module tb_apb_master_n;

    localparam int NS = 10;

    logic          clk;
    logic          rst_n;
    logic          transfer;
    logic          write;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          error;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PENABLE;
    logic [NS-1:0] PSEL;
    logic [NS*32-1:0] prdata_sig;
    logic [NS-1:0] pready_sig;
    logic [NS-1:0] pslverr_sig;

    int            checks;
    int            failures;

    // slave model controls
    int            wait_cfg;
    logic          err_cfg;
    logic [NS-1:0] noise;
    int            wcnt;

    apb_master_n #(
        .NUM_SLAVES (NS),
        .ADDR_W     (32),
        .DATA_W     (32),
        .BASE_ADDR  (32'h1000_0000),
        .SLOT_BITS  (12),
        .TIMEOUT    (4)
    ) dut (
        .PCLK     (clk),
        .PRESET   (rst_n),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (prdata_sig),
        .PREADY   (pready_sig),
        .PSLVERR  (pslverr_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) wcnt <= ((PSEL != '0) && PENABLE) ? wcnt + 1 : 0;

    always_comb begin
        pready_sig  = (noise & ~PSEL) | ((PENABLE && (wcnt >= wait_cfg)) ? PSEL : '0);
        pslverr_sig = (noise & ~PSEL) | (err_cfg ? PSEL : '0);
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr     = a;
        write    = w;
        wdata    = d;
        transfer = 1'b1;
        @(posedge clk);
        #1;
        transfer = 1'b0;
    endtask

    // Follows a transfer until ready, counting cycles since the accepting edge.
    task automatic run_xfer(input int start_c, input logic [31:0] exp_wdata,
                            output int cycles, output int psel_cyc, output int pen_cyc,
                            output logic [NS-1:0] psel_or, output int wdata_bad);
        cycles    = -1;
        psel_cyc  = 0;
        pen_cyc   = 0;
        psel_or   = '0;
        wdata_bad = 0;
        for (int c = start_c; c <= start_c + 40; c++) begin
            if (PSEL != '0) psel_cyc++;
            psel_or = psel_or | PSEL;
            if (PENABLE) pen_cyc++;
            if ((PSEL != '0) && (PWDATA !== exp_wdata)) wdata_bad++;
            if (ready) begin
                cycles = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        $display("txn addr=%h write=%0d cycles=%0d rdata=%h error=%0b", PADDR, PWRITE, cycles, rdata, error);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({PSEL, PENABLE, PWRITE, ready, error} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got psel=%b en=%b wr=%b rdy=%b err=%b required all 0", PSEL, PENABLE, PWRITE, ready, error);
        end
        checks++;
        if ({PADDR, PWDATA, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h required 0", PADDR, PWDATA, rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_wait_read;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        wait_cfg = 0; err_cfg = 1'b0; noise = '0;
        issue(32'h1000_2004, 1'b0, 32'h0);
        run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 3) begin failures++; $display("FAIL zw_latency: got %0d required 3", cyc); end
        checks++;
        if (po !== 10'b00_0000_0100 || pc !== 2) begin
            failures++; $display("FAIL zw_psel: got psel=%b for %0d cycles required 0000000100 for 2", po, pc);
        end
        checks++;
        if (rdata !== 32'hA5A5_0001 || error !== 1'b0) begin
            failures++; $display("FAIL zw_data: got rdata=%h err=%b required a5a50001 err=0", rdata, error);
        end
        checks++;
        if (PADDR !== 32'h1000_2004 || PWRITE !== 1'b0) begin
            failures++; $display("FAIL zw_paddr: got %h pwrite=%b required 10002004 pwrite=0", PADDR, PWRITE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || rdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL zw_pulse: got ready=%b rdata=%h required ready=0 rdata=a5a50001", ready, rdata);
        end
    endtask

    task automatic test_timeout;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        wait_cfg = 1000;
        issue(32'h1000_3000, 1'b0, 32'h0);
        run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (ec !== 4 || cyc !== 6) begin
            failures++; $display("FAIL to_length: got access=%0d done=%0d required access=4 done=6", ec, cyc);
        end
        checks++;
        if (error !== 1'b1 || rdata !== 32'h0 || PSEL !== '0 || PENABLE !== 1'b0) begin
            failures++; $display("FAIL to_result: got err=%b rdata=%h psel=%b en=%b required err=1 rdata=0 bus idle", error, rdata, PSEL, PENABLE);
        end
        wait_cfg = 0;
        @(posedge clk);
        #1;
        issue(32'h1000_1010, 1'b0, 32'h0);
        run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 3 || error !== 1'b0 || rdata !== 32'hC0DE_0001) begin
            failures++; $display("FAIL to_recover: got cycles=%0d err=%b rdata=%h required 3 0 c0de0001", cyc, error, rdata);
        end
    endtask

    task automatic test_decode_miss;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        logic [31:0] miss_addr [3];
        miss_addr[0] = 32'h1000_F000;
        miss_addr[1] = 32'h0FFF_FFFC;
        miss_addr[2] = 32'h1000_A000;
        for (int i = 0; i < 3; i++) begin
            issue(miss_addr[i], 1'b0, 32'h0);
            run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
            checks++;
            if (cyc !== 2 || po !== '0) begin
                failures++; $display("FAIL miss_%0d_timing: got cycles=%0d psel=%b required 2 and no psel", i, cyc, po);
            end
            checks++;
            if (error !== 1'b1 || rdata !== 32'h0) begin
                failures++; $display("FAIL miss_%0d_result: got err=%b rdata=%h required err=1 rdata=0", i, error, rdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wait_write;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        wait_cfg = 3;
        noise    = '1;
        issue(32'h1000_7000, 1'b1, 32'h0000_0055);
        run_xfer(1, 32'h0000_0055, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 6 || ec !== 4) begin
            failures++; $display("FAIL ww_latency: got done=%0d access=%0d required 6 and 4", cyc, ec);
        end
        checks++;
        if (po !== 10'b00_1000_0000 || wb !== 0 || PWRITE !== 1'b1) begin
            failures++; $display("FAIL ww_bus: got psel=%b pwdata_bad=%0d pwrite=%b required 0010000000 0 1", po, wb, PWRITE);
        end
        checks++;
        if (error !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL ww_result: got err=%b rdata=%h required err=0 rdata=0", error, rdata);
        end
        noise    = '0;
        wait_cfg = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        wait_cfg = 0;
        err_cfg  = 1'b1;
        issue(32'h1000_0020, 1'b0, 32'h0);
        run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 3 || error !== 1'b1 || rdata !== 32'hC0DE_0000) begin
            failures++; $display("FAIL slverr: got cycles=%0d err=%b rdata=%h required 3 1 c0de0000", cyc, error, rdata);
        end
        // Second request raised inside the ready cycle.
        err_cfg  = 1'b0;
        wait_cfg = 2;
        issue(32'h1000_9000, 1'b0, 32'h0);
        checks++;
        if (PSEL !== 10'b10_0000_0000 || PENABLE !== 1'b0) begin
            failures++; $display("FAIL b2b_setup: got psel=%b en=%b required 1000000000 en=0", PSEL, PENABLE);
        end
        @(posedge clk);
        #1;
        issue(32'h1000_5000, 1'b1, 32'hFFFF_FFFF);
        run_xfer(3, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 5 || error !== 1'b0 || rdata !== 32'hC0DE_0009) begin
            failures++; $display("FAIL b2b_second: got cycles=%0d err=%b rdata=%h required 5 0 c0de0009", cyc, error, rdata);
        end
        checks++;
        if (PADDR !== 32'h1000_9000 || po !== 10'b10_0000_0000) begin
            failures++; $display("FAIL ignore_xfer: got paddr=%h psel=%b required 10009000 1000000000", PADDR, po);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (PSEL !== '0 || ready !== 1'b0) begin
            failures++; $display("FAIL ignore_idle: got psel=%b ready=%b required 0 0", PSEL, ready);
        end
        wait_cfg = 0;
    endtask

    task automatic test_async_reset;
        int cyc, pc, ec, wb;
        logic [NS-1:0] po;
        logic seen;
        wait_cfg = 1000;
        issue(32'h1000_4008, 1'b1, 32'h1234_5678);
        @(posedge clk);
        #1;
        checks++;
        if (PENABLE !== 1'b1 || PSEL !== 10'b00_0001_0000) begin
            failures++; $display("FAIL ar_access: got psel=%b en=%b required 0000010000 1", PSEL, PENABLE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, ready, error} !== '0 || {PADDR, PWDATA, rdata} !== '0) begin
            failures++; $display("FAIL ar_clear: got psel=%b en=%b wr=%b paddr=%h pwdata=%h rdata=%h required all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        #3;
        rst_n    = 1'b1;
        wait_cfg = 0;
        @(posedge clk);
        #1;
        if (ready) seen = 1'b1;
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL ar_no_ready: got ready pulse=%b required 0", seen);
        end
        issue(32'h1000_2000, 1'b0, 32'h0);
        run_xfer(1, 32'h0, cyc, pc, ec, po, wb);
        checks++;
        if (cyc !== 3 || error !== 1'b0 || rdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL ar_after: got cycles=%0d err=%b rdata=%h required 3 0 a5a50001", cyc, error, rdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        wait_cfg = 0;
        err_cfg  = 1'b0;
        noise    = '0;
        wcnt     = 0;
        for (int i = 0; i < NS; i++) prdata_sig[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        prdata_sig[2*32 +: 32] = 32'hA5A5_0001;

        test_reset;
        test_zero_wait_read;
        test_timeout;
        test_decode_miss;
        test_wait_write;
        test_back_to_back;
        test_async_reset;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at 20000 required finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_n.md
# apb_master_n

Parametrised APB master bridging the RV32I core's data-memory port to `NUM_SLAVES` APB peripherals (RAM, GPO, GPI, GPIO, FND, timer, UART, ultrasonic, DHT, and future slots) through a regular address map. It runs an IDLE/SETUP/ACCESS state machine and handles per-slave `PREADY`/`PSLVERR`. It also adds what the fixed 10-slave bridge lacks: decode-miss errors, a stalled-slave timeout, and an error flag back to the core. It sits between `RV32I_Core` and the peripheral instances inside `MCU`.

## Interface
- `NUM_SLAVES`, 10, number of APB slave slots (1..16)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `BASE_ADDR`, 32'h1000_0000, address of slot 0
- `SLOT_BITS`, 12, log2 of slot size (4 KB per slave)
- `TIMEOUT`, 255, ACCESS cycles before abort; 0 disables timeout
- `PCLK` in 1: clock
- `PRESET` in 1: asynchronous, active-low reset
- `transfer` in 1: request strobe from core, sampled only in IDLE
- `write` in 1: 1 = write, 0 = read
- `addr` in ADDR_W: byte address
- `wdata` in DATA_W: write data
- `rdata` out DATA_W: read data, valid while `ready`=1
- `ready` out 1: one-cycle completion pulse
- `error` out 1: qualifies `ready`; set on decode miss, timeout, or slave PSLVERR
- `PADDR` out ADDR_W
- `PWDATA` out DATA_W
- `PWRITE` out 1
- `PENABLE` out 1
- `PSEL` out NUM_SLAVES: one-hot slave select
- `PRDATA` in NUM_SLAVES×DATA_W: packed per-slave read data
- `PREADY` in NUM_SLAVES: per-slave ready
- `PSLVERR` in NUM_SLAVES: per-slave error; tie 0 for slaves without error support

## Operation
- States: IDLE, SETUP, ACCESS, DECERR.
- **IDLE**
  - On `transfer`=1, register `addr`, `wdata`, `write` into `PADDR`/`PWDATA`/`PWRITE`.
  - Decode the address:
    - Hit: `addr` ≥ `BASE_ADDR` and slot index `(addr-BASE_ADDR)>>SLOT_BITS` < `NUM_SLAVES`. Go to SETUP.
    - Miss: go to DECERR.
- **SETUP**: `PSEL[idx]`=1, `PENABLE`=0. Always go to ACCESS next.
- **ACCESS**: `PSEL[idx]`=1, `PENABLE`=1. The timeout counter increments each cycle.
  - `PREADY[idx]`=1: capture `PRDATA[idx]` into `rdata` (reads only; writes return 0) and `PSLVERR[idx]` into `error`. Pulse `ready`, go to IDLE.
  - Else, if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1: pulse `ready` with `error`=1 and `rdata`=0, deassert PSEL/PENABLE, go to IDLE.
- **DECERR**: no PSEL asserted. Pulse `ready` with `error`=1 and `rdata`=0, go to IDLE.
- `PREADY`/`PSLVERR` from unselected slaves are ignored.
- `transfer` in any state other than IDLE is ignored; the core must hold off until `ready`.

## Timing
- All outputs are registered.
- Reset values: `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0, `rdata`=0, `ready`=0, `error`=0, state IDLE, counter 0.
- Reset asserted mid-transfer: the bus drops immediately (async). No `ready` is issued for the aborted transfer.
- Zero-wait slave: `transfer` sampled at edge E0 → SETUP after E0 → ACCESS after E1 → `ready` high during the cycle after E2. Each wait state adds one cycle.
- Decode miss: `ready`+`error` appear 2 cycles after `transfer` is sampled.
- Back-to-back: `transfer` sampled at the same edge that ends the `ready` cycle (state is IDLE) is accepted. The minimum request period is 3 cycles.
- Timeout: with `TIMEOUT`=N, ACCESS lasts at most N cycles.
- The counter is `$clog2(TIMEOUT+1)` bits wide and clears on entry to SETUP.
- `ready` is exactly one cycle wide. `rdata`/`error` hold their values until the next completion.

## Structure
- Package `apb_pkg`:
  - `apb_state_e` (IDLE, SETUP, ACCESS, DECERR)
  - default `BASE_ADDR`, `SLOT_BITS`
  - localparam slot indices for RAM=0, GPO=1, GPI=2, GPIOC=3, GPIOD=4, FND=5, TIMER=6, UART=7, US=8, DHT=9
- Sub-module `apb_addr_decoder`: combinational. Takes `addr`, outputs the one-hot select vector, `hit`, and the slot index. It is reused by the bus monitor.

## Test plan
- Zero-wait read of slot 2: `addr`=0x1000_2004, slave returns 0xA5A5_0001 → `PSEL`=0b100 for 2 cycles, `ready`+`rdata`=0xA5A5_0001, `error`=0, 3 cycles after request.
- Write to slot 7 with slave inserting 3 wait states: `PWDATA`=0x55 held through ACCESS, `ready` after 6 cycles, `error`=0.
- Decode miss: `addr`=0x1000_F000 with `NUM_SLAVES`=10, and `addr`=0x0FFF_FFFC → no PSEL ever, `ready`+`error`=1, `rdata`=0 after 2 cycles.
- Timeout with `TIMEOUT`=4, slave never ready: ACCESS lasts exactly 4 cycles, then `ready`+`error`. The next request to a healthy slave completes normally.
- `PSLVERR` on slot 0 read plus back-to-back request issued in the `ready` cycle → `error`=1 on the first, the second accepted with no idle gap. `transfer` pulses during ACCESS are ignored.
- Async reset asserted in ACCESS → all outputs 0 without a clock edge, and no `ready`. The first request after reset completes normally.
